// File: rtl/resp_checker_pkg.sv
// Shared types and default constants for the exhaustive-sweep response checker.
package resp_checker_pkg;

   localparam int RC_IDX_W = 4;
   localparam int RC_N_VEC = 16;

   // Truth table of the 4-input composite function: ones at vectors 4, 10, 12..15.
   localparam logic [RC_N_VEC-1:0] RC_GOLDEN = 16'hF410;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } rc_state_t;

endpackage

// File: rtl/resp_checker_scoreboard.sv
// Result registers for one sweep: captured response word, error count,
// first failing index and sticky sequence-error flag.
module resp_scoreboard
   import resp_checker_pkg::*;
#(
   parameter int                N_VEC  = RC_N_VEC,
   parameter int                IDX_W  = RC_IDX_W,
   parameter logic [N_VEC-1:0]  GOLDEN = RC_GOLDEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             accept,
   input  logic [IDX_W-1:0] vec_idx,
   input  logic             resp,
   input  logic [IDX_W-1:0] exp_idx,
   output logic [N_VEC-1:0] resp_word,
   output logic [IDX_W:0]   err_count,
   output logic [IDX_W-1:0] first_err_idx,
   output logic             seq_err
);

   logic mismatch;

   assign mismatch = (resp != GOLDEN[vec_idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_word     <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         seq_err       <= 1'b0;
      end else if (clear) begin
         resp_word     <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         seq_err       <= 1'b0;
      end else if (accept) begin
         resp_word[vec_idx] <= resp;
         if (mismatch) begin
            err_count <= err_count + {{IDX_W{1'b0}}, 1'b1};
            // An empty error count marks this as the first failing vector.
            if (err_count == '0)
               first_err_idx <= vec_idx;
         end
         if (vec_idx != exp_idx)
            seq_err <= 1'b1;
      end
   end

endmodule

// File: rtl/resp_checker.sv
// Response checker top: sweep FSM, expected-index counter and sample handshake,
// with results held in resp_scoreboard.
module resp_checker
   import resp_checker_pkg::*;
#(
   parameter int                N_VEC  = RC_N_VEC,
   parameter int                IDX_W  = RC_IDX_W,
   parameter logic [N_VEC-1:0]  GOLDEN = RC_GOLDEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vec_valid,
   input  logic [IDX_W-1:0] vec_idx,
   input  logic             resp,
   output logic             vec_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_VEC-1:0] resp_word,
   output logic [IDX_W:0]   err_count,
   output logic [IDX_W-1:0] first_err_idx,
   output logic             seq_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

   rc_state_t        state;
   logic [IDX_W-1:0] exp_idx;
   logic             accept;

   // start has priority: a sample coinciding with an abort is dropped.
   assign accept = (state == COLLECT) && vec_valid && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         exp_idx   <= '0;
         vec_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= COLLECT;
                  exp_idx   <= '0;
                  vec_ready <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            COLLECT: begin
               if (start) begin
                  exp_idx <= '0;
               end else if (vec_valid) begin
                  exp_idx <= (exp_idx == LAST_IDX) ? '0 : exp_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                  if (exp_idx == LAST_IDX) begin
                     state     <= DONE;
                     vec_ready <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               exp_idx   <= '0;
               vec_ready <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

   resp_scoreboard #(
      .N_VEC  (N_VEC),
      .IDX_W  (IDX_W),
      .GOLDEN (GOLDEN)
   ) u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (start),
      .accept        (accept),
      .vec_idx       (vec_idx),
      .resp          (resp),
      .exp_idx       (exp_idx),
      .resp_word     (resp_word),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .seq_err       (seq_err)
   );

   assign pass = done && (err_count == '0) && !seq_err;

endmodule

// File: tb/tb_resp_checker.sv
// Directed bench for resp_checker: clean, faulty, gapped, out-of-order,
// reset and abort sweeps against hand-computed results.
module tb_resp_checker;

   localparam logic [15:0] GOLD = 16'hF410;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        vec_valid = 1'b0;
   logic [3:0]  vec_idx = '0;
   logic        resp = 1'b0;
   logic        vec_ready, busy, done, pass, seq_err;
   logic [15:0] resp_word;
   logic [4:0]  err_count;
   logic [3:0]  first_err_idx;

   int tests = 0;
   int fails = 0;

   resp_checker dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .vec_valid     (vec_valid),
      .vec_idx       (vec_idx),
      .resp          (resp),
      .vec_ready     (vec_ready),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .resp_word     (resp_word),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .seq_err       (seq_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0h required %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] idx, input logic r);
      vec_valid = 1'b1;
      vec_idx   = idx;
      resp      = r;
      tick();
      vec_valid = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic d, input logic p,
                            input logic [15:0] w, input logic [4:0] e,
                            input logic [3:0] f, input logic s);
      chk({tag, "_done"},  32'(done),          32'(d));
      chk({tag, "_pass"},  32'(pass),          32'(p));
      chk({tag, "_word"},  32'(resp_word),     32'(w));
      chk({tag, "_errs"},  32'(err_count),     32'(e));
      chk({tag, "_first"}, 32'(first_err_idx), 32'(f));
      chk({tag, "_seq"},   32'(seq_err),       32'(s));
   endtask

   // rv gives the response bit per vector index; swap23 sends index order 0,1,3,2,4..15.
   task automatic run_sweep(input string tag, input logic [15:0] rv,
                            input bit gaps, input bit swap23);
      logic [3:0] idx;
      pulse_start();
      chk({tag, "_busy_start"},  32'(busy),      32'd1);
      chk({tag, "_ready_start"}, 32'(vec_ready), 32'd1);
      for (int i = 0; i < 16; i++) begin
         idx = 4'(i);
         if (swap23 && i == 2) idx = 4'd3;
         if (swap23 && i == 3) idx = 4'd2;
         if (i == 15) chk({tag, "_done_before_last"}, 32'(done), 32'd0);
         send(idx, rv[idx]);
         if (i == 15) begin
            chk({tag, "_done_latency"}, 32'(done),      32'd1);
            chk({tag, "_ready_done"},   32'(vec_ready), 32'd0);
         end else if (gaps) begin
            tick();
         end
      end
   endtask

   initial begin
      // Reset state
      #2;
      check_all("reset", 1'b0, 1'b0, 16'h0000, 5'd0, 4'd0, 1'b0);
      chk("reset_busy",  32'(busy),      32'd0);
      chk("reset_ready", 32'(vec_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Stray sample while idle is ignored
      send(4'd4, 1'b1);
      chk("idle_stray_busy", 32'(busy), 32'd0);
      chk("idle_stray_word", 32'(resp_word), 32'd0);

      // Clean sweep
      run_sweep("clean", GOLD, 1'b0, 1'b0);
      check_all("clean", 1'b1, 1'b1, 16'hF410, 5'd0, 4'd0, 1'b0);

      // Single fault at vector 10
      run_sweep("fault10", 16'hF010, 1'b0, 1'b0);
      check_all("fault10", 1'b1, 1'b0, 16'hF010, 5'd1, 4'd10, 1'b0);

      // Stuck-at-one output: 10 mismatches, first at vector 0
      run_sweep("ones", 16'hFFFF, 1'b0, 1'b0);
      check_all("ones", 1'b1, 1'b0, 16'hFFFF, 5'd10, 4'd0, 1'b0);

      // Gapped clean sweep, then a stray sample in DONE
      run_sweep("gaps", GOLD, 1'b1, 1'b0);
      check_all("gaps", 1'b1, 1'b1, 16'hF410, 5'd0, 4'd0, 1'b0);
      send(4'd0, 1'b1);
      tick();
      check_all("done_stray", 1'b1, 1'b1, 16'hF410, 5'd0, 4'd0, 1'b0);

      // Out-of-order indices
      run_sweep("swap", GOLD, 1'b0, 1'b1);
      check_all("swap", 1'b1, 1'b0, 16'hF410, 5'd0, 4'd0, 1'b1);

      // Asynchronous reset mid-sweep after 8 stuck-at-one accepts
      pulse_start();
      for (int i = 0; i < 8; i++) send(4'(i), 1'b1);
      chk("pre_reset_errs", 32'(err_count), 32'd7);
      chk("pre_reset_word", 32'(resp_word), 32'h00FF);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 1'b0, 1'b0, 16'h0000, 5'd0, 4'd0, 1'b0);
      chk("async_rst_busy",  32'(busy),      32'd0);
      chk("async_rst_ready", 32'(vec_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_sweep("post_rst", GOLD, 1'b0, 1'b0);
      check_all("post_rst", 1'b1, 1'b1, 16'hF410, 5'd0, 4'd0, 1'b0);

      // Abort after 5 bad accepts; a sample alongside start is dropped
      pulse_start();
      for (int i = 0; i < 5; i++) send(4'(i), 1'b1);
      chk("pre_abort_errs", 32'(err_count), 32'd4);
      start     = 1'b1;
      vec_valid = 1'b1;
      vec_idx   = 4'd5;
      resp      = 1'b1;
      tick();
      start     = 1'b0;
      vec_valid = 1'b0;
      chk("abort_busy", 32'(busy),      32'd1);
      chk("abort_word", 32'(resp_word), 32'd0);
      chk("abort_errs", 32'(err_count), 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("abort_done_before_last", 32'(done), 32'd0);
         send(4'(i), GOLD[i]);
      end
      check_all("abort", 1'b1, 1'b1, 16'hF410, 5'd0, 4'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/resp_checker.md
Name: resp_checker

Overview:
- Response-side counterpart of the exhaustive 4-bit stimulus generator: captures one DUT output bit per applied input vector over a full sweep.
- Assembles the captured bits into a response word and compares each bit, as it arrives, against a golden truth table.
- Reports pass/fail, error count and first failing vector.
- Sits in the workbench between the DUT output and the bench's end-of-test reporting. It replaces manual $monitor inspection with a self-checking result.

Parameters:
- N_VEC, 16, number of vectors per sweep (2**IDX_W).
- IDX_W, 4, width of vector index.
- GOLDEN, 16'hF410, expected response; bit i = expected DUT output for input vector i. Default is the truth table of the 4-input composite function: ones at vectors 4, 10, 12, 13, 14, 15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; clears results and begins a sweep.
- vec_valid  input  1  resp/vec_idx carry a sample this cycle.
- vec_idx  input  IDX_W  index of the input vector that produced resp.
- resp  input  1  DUT output bit for vec_idx.
- vec_ready  output  1  checker accepts a sample this cycle.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; results valid.
- pass  output  1  sweep matched GOLDEN with no sequence error; valid only when done=1.
- resp_word  output  N_VEC  captured responses, bit i = resp received for index i.
- err_count  output  IDX_W+1  number of mismatching samples (0..16).
- first_err_idx  output  IDX_W  index of first mismatch; 0 if none.
- seq_err  output  1  a sample arrived with vec_idx != expected counter.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including resp_word, err_count, first_err_idx, seq_err and the internal expected-index counter.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: vec_ready=0, busy=0. start -> COLLECT and clear all results.
  - COLLECT: vec_ready=1, busy=1. An accept occurs on a rising edge with vec_valid=1.
  - DONE: done=1, vec_ready=0. Results are held until start, which clears them and returns to COLLECT.
- On each accept:
  - resp_word[vec_idx] <= resp.
  - Expected counter increments, modulo N_VEC.
  - If resp != GOLDEN[vec_idx]: err_count increments. If this is the first error, first_err_idx <= vec_idx.
  - If vec_idx != expected counter: seq_err <= 1 (sticky until start/reset). The sample is still stored at vec_idx.
- Completion:
  - The accept with expected counter = N_VEC-1 moves the FSM to DONE on that same edge.
  - done is high from the next cycle.
  - Latency from the 16th accept to done: 1 cycle.
- pass = done & (err_count==0) & ~seq_err. Combinational from registers. It is 0 whenever done=0.
- start in COLLECT: abort and restart. Results are cleared and the counter goes to 0 on that edge; any vec_valid in the same cycle is ignored.
- vec_valid in IDLE or DONE: ignored, no state change.
- err_count cannot exceed N_VEC, so no saturation logic is required. first_err_idx=0 is ambiguous on its own; qualify it with err_count!=0.
- Gaps in vec_valid are legal and have no timeout.

Decomposition:
- Package resp_checker_pkg:
  - State enum (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2).
  - Default GOLDEN constant 16'hF410.
  - IDX_W/N_VEC constants.
- Sub-module resp_scoreboard: holds resp_word, err_count, first_err_idx and seq_err, with accept/clear strobes from the FSM.
- Top level resp_checker holds the FSM, the expected counter and the handshake.

Test Plan:
- Reset, start, then 16 accepts with idx 0..15 and resp=GOLDEN[idx] -> done=1 one cycle after the 16th accept, pass=1, resp_word=16'hF410, err_count=0, seq_err=0.
- Same sweep with resp at idx 10 forced to 0 -> resp_word=16'hF010, err_count=1, first_err_idx=10, pass=0.
- Sweep with resp=1 on all vectors -> resp_word=16'hFFFF, err_count=10, first_err_idx=0, pass=0.
- Correct sweep with vec_valid high only on alternate cycles, plus vec_valid pulses while in IDLE and DONE -> identical to the first case; the stray pulses cause no change; done asserts only after the 16th accept.
- Correct responses but idx sequence 0,1,3,2,4..15 -> seq_err=1, err_count=0, pass=0.
- rst_n low for 1 cycle after 8 accepts -> all outputs 0 immediately (before the next clock edge); a following start and full correct sweep gives pass=1. Also: start asserted after 5 accepts -> counter restarts and the result equals a fresh sweep.
